// File: rtl/fsmc_reg_bridge.sv
// fsmc_reg_bridge: synchronous FSMC slave front-end.
// Synchronises the asynchronous FSMC pins into the clk domain.
// Turns each completed bus write into a one-cycle register write strobe.
// Turns each bus read into a one-cycle read request, then drives the returned word onto the pad.
module fsmc_reg_bridge #(
  parameter int AW = 4,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          aNE,
  input  logic          aNOE,
  input  logic          aNWE,
  input  logic [AW-1:0] aA,
  input  logic [DW-1:0] aD_in,
  output logic [DW-1:0] aD_out,
  output logic          aD_oe,
  output logic          wr_stb,
  output logic [AW-1:0] wr_adr,
  output logic [DW-1:0] wr_data,
  output logic          rd_stb,
  output logic [AW-1:0] rd_adr,
  input  logic [DW-1:0] rd_data,
  output logic          proto_err
);

  typedef enum logic [2:0] {IDLE, WR, RD_WAIT, RD_HOLD, ERR} state_t;

  state_t        state;
  logic          rd_dly;
  logic [1:0]    ne_q, noe_q, nwe_q;
  logic [AW-1:0] a_q1, sA;
  logic [DW-1:0] d_q1, sD;
  logic          sNE, sNOE, sNWE;

  assign sNE  = ne_q[1];
  assign sNOE = noe_q[1];
  assign sNWE = nwe_q[1];

  // Two-flop synchronisers; strobes idle high, address/data idle low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ne_q  <= '1;
      noe_q <= '1;
      nwe_q <= '1;
      a_q1  <= '0;
      sA    <= '0;
      d_q1  <= '0;
      sD    <= '0;
    end else begin
      ne_q  <= {ne_q[0], aNE};
      noe_q <= {noe_q[0], aNOE};
      nwe_q <= {nwe_q[0], aNWE};
      a_q1  <= aA;
      sA    <= a_q1;
      d_q1  <= aD_in;
      sD    <= d_q1;
    end
  end

  // Bus-cycle FSM with registered strobes and pad controls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rd_dly    <= 1'b0;
      wr_stb    <= 1'b0;
      rd_stb    <= 1'b0;
      proto_err <= 1'b0;
      aD_oe     <= 1'b0;
      aD_out    <= '0;
      wr_adr    <= '0;
      wr_data   <= '0;
      rd_adr    <= '0;
    end else begin
      wr_stb    <= 1'b0;
      rd_stb    <= 1'b0;
      proto_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!sNE) begin
            if (!sNOE && !sNWE) begin
              proto_err <= 1'b1;
              state     <= ERR;
            end else if (!sNWE) begin
              state <= WR;
            end else if (!sNOE) begin
              rd_stb <= 1'b1;
              rd_adr <= sA;
              rd_dly <= 1'b0;
              state  <= RD_WAIT;
            end
          end
        end
        WR: begin
          // wr_adr/wr_data double as the holding registers; they only
          // change while the write is still in progress.
          if (!sNOE) begin
            proto_err <= 1'b1;
            state     <= ERR;
          end else if (sNWE || sNE) begin
            wr_stb <= 1'b1;
            state  <= IDLE;
          end else begin
            wr_adr  <= sA;
            wr_data <= sD;
          end
        end
        RD_WAIT: begin
          // rd_data is valid the cycle after rd_stb, which overlaps the
          // first RD_WAIT cycle, so capture happens on the second edge.
          if (rd_dly) begin
            aD_out <= rd_data;
            aD_oe  <= 1'b1;
            state  <= RD_HOLD;
          end else begin
            rd_dly <= 1'b1;
          end
        end
        RD_HOLD: begin
          if (sNOE || sNE) begin
            aD_oe <= 1'b0;
            state <= IDLE;
          end
        end
        ERR: begin
          aD_oe <= 1'b0;
          if (sNE) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsmc_reg_bridge.sv
// Testbench for fsmc_reg_bridge: scenario tasks with a strobe scoreboard.
module tb_fsmc_reg_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        aNE, aNOE, aNWE;
  logic [3:0]  aA;
  logic [15:0] aD_in;
  logic [15:0] aD_out;
  logic        aD_oe;
  logic        wr_stb;
  logic [3:0]  wr_adr;
  logic [15:0] wr_data;
  logic        rd_stb;
  logic [3:0]  rd_adr;
  logic [15:0] rd_data;
  logic        proto_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  adr;
    logic [15:0] data;
  } wr_t;

  wr_t        wq[$];
  logic [3:0] rq[$];
  int         pe_exp  = 0;
  int         wr_seen = 0;
  int         pe_seen = 0;
  logic [15:0] regs [16];

  fsmc_reg_bridge #(.AW(4), .DW(16)) dut (
    .clk(clk), .rst(rst), .aNE(aNE), .aNOE(aNOE), .aNWE(aNWE),
    .aA(aA), .aD_in(aD_in), .aD_out(aD_out), .aD_oe(aD_oe),
    .wr_stb(wr_stb), .wr_adr(wr_adr), .wr_data(wr_data),
    .rd_stb(rd_stb), .rd_adr(rd_adr), .rd_data(rd_data),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Register file model: read data valid the cycle after rd_stb.
  always @(posedge clk) begin
    if (rd_stb) rd_data <= regs[rd_adr];
  end

  // Scoreboard: every strobe must match a pending expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_stb) begin
        wr_seen++;
        checks++;
        if (wq.size() == 0) begin
          failures++;
          $display("FAIL wr_unexpected: got adr=%h data=%h, required none", wr_adr, wr_data);
        end else begin
          wr_t e;
          e = wq.pop_front();
          if (wr_adr !== e.adr || wr_data !== e.data) begin
            failures++;
            $display("FAIL wr_match: got adr=%h data=%h, required adr=%h data=%h",
                     wr_adr, wr_data, e.adr, e.data);
          end
        end
      end
      if (rd_stb) begin
        checks++;
        if (rq.size() == 0) begin
          failures++;
          $display("FAIL rd_unexpected: got adr=%h, required none", rd_adr);
        end else begin
          logic [3:0] ea;
          ea = rq.pop_front();
          if (rd_adr !== ea) begin
            failures++;
            $display("FAIL rd_match: got adr=%h, required adr=%h", rd_adr, ea);
          end
        end
      end
      if (proto_err) begin
        pe_seen++;
        checks++;
        if (pe_exp == 0) begin
          failures++;
          $display("FAIL perr_unexpected: got proto_err=1, required 0");
        end else begin
          pe_exp--;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Counts clk edges from now until the selected condition is seen; -1 on timeout.
  task automatic lat_to(input int which, output int n);
    logic hit;
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      case (which)
        0:       hit = (wr_stb === 1'b1);
        1:       hit = (rd_stb === 1'b1);
        2:       hit = (aD_oe === 1'b1);
        default: hit = (aD_oe === 1'b0);
      endcase
      if (hit) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    aNE = 1'b1; aNOE = 1'b1; aNWE = 1'b1; aA = '0; aD_in = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({wr_stb, rd_stb, proto_err, aD_oe} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_strobes: got %b, required 0000", {wr_stb, rd_stb, proto_err, aD_oe});
    end
    checks++;
    if ({wr_adr, rd_adr, wr_data, aD_out} !== 40'h0) begin
      failures++;
      $display("FAIL reset_values: got %h, required 0", {wr_adr, rd_adr, wr_data, aD_out});
    end
    tick(1);
    rst = 1'b0;
    tick(3);
  endtask

  task automatic test_single_write;
    int n;
    aNE = 1'b0; aA = 4'h3; aD_in = 16'hBEEF; aNWE = 1'b0;
    tick(6);
    wq.push_back('{adr: 4'h3, data: 16'hBEEF});
    aNWE = 1'b1;
    lat_to(0, n);
    checks++;
    if (n !== 3) begin
      failures++;
      $display("FAIL write_latency: got %0d clk, required 3", n);
    end
    aNE = 1'b1;
    tick(4);
  endtask

  task automatic test_single_read;
    int n;
    aNE = 1'b0; aA = 4'h5;
    tick(3);
    rq.push_back(4'h5);
    aNOE = 1'b0;
    lat_to(1, n);
    checks++;
    if (n !== 3) begin
      failures++;
      $display("FAIL rd_stb_latency: got %0d clk, required 3", n);
    end
    lat_to(2, n);
    checks++;
    if (n !== 2) begin
      failures++;
      $display("FAIL oe_rise_latency: got %0d further clk, required 2 (5 total)", n);
    end
    checks++;
    if (aD_out !== 16'h1234) begin
      failures++;
      $display("FAIL read_data: got %h, required 1234", aD_out);
    end
    tick(5);
    checks++;
    if (aD_oe !== 1'b1 || aD_out !== 16'h1234) begin
      failures++;
      $display("FAIL read_hold: got oe=%b data=%h, required oe=1 data=1234", aD_oe, aD_out);
    end
    aNOE = 1'b1;
    lat_to(3, n);
    checks++;
    if (n !== 3) begin
      failures++;
      $display("FAIL oe_release_latency: got %0d clk, required 3", n);
    end
    aNE = 1'b1;
    tick(4);
  endtask

  task automatic test_back_to_back;
    int n;
    int base;
    base = wr_seen;
    aNE = 1'b0; aA = 4'h1; aD_in = 16'h00AA; aNWE = 1'b0;
    tick(5);
    wq.push_back('{adr: 4'h1, data: 16'h00AA});
    aNWE = 1'b1;
    lat_to(0, n);
    checks++;
    if (n !== 3) begin
      failures++;
      $display("FAIL b2b_first_latency: got %0d clk, required 3", n);
    end
    aA = 4'h2; aD_in = 16'h0055; aNWE = 1'b0;
    tick(5);
    wq.push_back('{adr: 4'h2, data: 16'h0055});
    aNWE = 1'b1;
    lat_to(0, n);
    checks++;
    if (n !== 3) begin
      failures++;
      $display("FAIL b2b_second_latency: got %0d clk, required 3", n);
    end
    aNE = 1'b1;
    tick(4);
    checks++;
    if (wr_seen - base !== 2) begin
      failures++;
      $display("FAIL b2b_count: got %0d writes, required 2", wr_seen - base);
    end
  endtask

  task automatic test_proto_err;
    int n;
    int base;
    base = pe_seen;
    aNE = 1'b0; aA = 4'h6;
    tick(3);
    pe_exp++;
    aNOE = 1'b0; aNWE = 1'b0;
    tick(6);
    checks++;
    if (aD_oe !== 1'b0) begin
      failures++;
      $display("FAIL perr_oe_low: got %b, required 0", aD_oe);
    end
    aNOE = 1'b1; aNWE = 1'b1;
    tick(4);
    aNWE = 1'b0;
    tick(4);
    aNWE = 1'b1;
    tick(4);
    checks++;
    if (pe_seen - base !== 1 || aD_oe !== 1'b0) begin
      failures++;
      $display("FAIL perr_count: got %0d pulses oe=%b, required 1 pulse oe=0", pe_seen - base, aD_oe);
    end
    aNE = 1'b1;
    tick(4);
    aNE = 1'b0; aA = 4'h7; aD_in = 16'h1357; aNWE = 1'b0;
    tick(6);
    wq.push_back('{adr: 4'h7, data: 16'h1357});
    aNWE = 1'b1;
    lat_to(0, n);
    checks++;
    if (n !== 3) begin
      failures++;
      $display("FAIL perr_recover_latency: got %0d clk, required 3", n);
    end
    aNE = 1'b1;
    tick(4);
  endtask

  task automatic test_reset_mid_read;
    int n;
    aNE = 1'b0; aA = 4'h5;
    tick(3);
    rq.push_back(4'h5);
    aNOE = 1'b0;
    lat_to(2, n);
    tick(2);
    rst = 1'b1;
    #1;
    checks++;
    if ({aD_oe, rd_stb, wr_stb} !== 3'b000) begin
      failures++;
      $display("FAIL reset_async: got oe/rd/wr=%b, required 000", {aD_oe, rd_stb, wr_stb});
    end
    aNE = 1'b1; aNOE = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(8);
    checks++;
    if ({aD_oe, rd_stb, wr_stb, proto_err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_idle: got %b, required 0000", {aD_oe, rd_stb, wr_stb, proto_err});
    end
  endtask

  task automatic test_ne_abort;
    int n;
    aNE = 1'b0; aA = 4'h9; aD_in = 16'hC0DE; aNWE = 1'b0;
    tick(4);
    wq.push_back('{adr: 4'h9, data: 16'hC0DE});
    aNE = 1'b1; aNWE = 1'b1;
    lat_to(0, n);
    checks++;
    if (n !== 3) begin
      failures++;
      $display("FAIL ne_abort_latency: got %0d clk, required 3", n);
    end
    tick(4);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 16'(i * 16'h0111);
    regs[5] = 16'h1234;
    test_reset;
    test_single_write;
    test_single_read;
    test_back_to_back;
    test_proto_err;
    test_reset_mid_read;
    test_ne_abort;
    checks++;
    if (wq.size() != 0 || rq.size() != 0 || pe_exp != 0) begin
      failures++;
      $display("FAIL pending: got wq=%0d rq=%0d perr=%0d, required 0 0 0", wq.size(), rq.size(), pe_exp);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
